// File: rtl/uart_cmd_rcv.sv
// 8N1 UART receiver that assembles pairs of bytes into a 16-bit command.
// The first byte of a pair becomes the high byte; a stop-bit error drops any partial pair.
module uart_cmd_rcv #(
  parameter int BAUD_CNT = 2604,
  parameter int HALF_CNT = 1302
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  input  logic        clr_cmd_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  output logic        frm_err
);

  localparam int CW = $clog2(BAUD_CNT + 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} byte_state_e;
  typedef enum logic       {WAIT_HI, WAIT_LO}        asm_state_e;

  byte_state_e r_byte_st, w_byte_nxt;
  asm_state_e  r_asm_st,  w_asm_nxt;

  logic          r_rx_meta, r_rx_sync, r_rx_prev;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic [7:0]    r_hold, w_hold_nxt;
  logic [15:0]   r_cmd, w_cmd_nxt;
  logic          r_cmd_rdy, w_rdy_nxt;
  logic          r_frm_err;
  logic          w_fall, w_cnt_zero, w_byte_ok, w_frm_err;

  // Sync flops preset to idle-high, so a line held low across reset release
  // looks like a fresh falling edge.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall     = r_rx_prev & ~r_rx_sync;
  assign w_cnt_zero = (r_cnt == '0);

  // The zero cycle is part of each interval, hence the -1 on every reload.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_byte_nxt  = r_byte_st;
    w_cnt_nxt   = w_cnt_zero ? r_cnt : r_cnt - 1'b1;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_byte_ok   = 1'b0;
    w_frm_err   = 1'b0;
    case (r_byte_st)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_fall) begin
          w_byte_nxt = START;
          w_cnt_nxt  = CW'(HALF_CNT - 1);
        end
      end
      START: if (w_cnt_zero) begin
        if (!r_rx_sync) begin
          w_byte_nxt = DATA;
          w_cnt_nxt  = CW'(BAUD_CNT - 1);
          w_bit_nxt  = 3'd0;
        end else begin
          w_byte_nxt = IDLE;
        end
      end
      DATA: if (w_cnt_zero) begin
        w_shift_nxt = {r_rx_sync, r_shift[7:1]};
        w_cnt_nxt   = CW'(BAUD_CNT - 1);
        w_bit_nxt   = r_bit + 3'd1;
        if (r_bit == 3'd7) w_byte_nxt = STOP;
      end
      STOP: if (w_cnt_zero) begin
        w_byte_ok  = r_rx_sync;
        w_frm_err  = ~r_rx_sync;
        w_byte_nxt = IDLE;
      end
      default: w_byte_nxt = IDLE;
    endcase
  end

  // Set beats clear: the default clear is overridden when a low byte lands.
  always_comb begin
    w_asm_nxt  = r_asm_st;
    w_hold_nxt = r_hold;
    w_cmd_nxt  = r_cmd;
    w_rdy_nxt  = r_cmd_rdy & ~clr_cmd_rdy;
    if (w_frm_err) begin
      w_asm_nxt = WAIT_HI;
    end else if (w_byte_ok) begin
      case (r_asm_st)
        WAIT_HI: begin
          w_hold_nxt = r_shift;
          w_rdy_nxt  = 1'b0;
          w_asm_nxt  = WAIT_LO;
        end
        WAIT_LO: begin
          w_cmd_nxt = {r_hold, r_shift};
          w_rdy_nxt = 1'b1;
          w_asm_nxt = WAIT_HI;
        end
        default: w_asm_nxt = WAIT_HI;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_st <= IDLE;
      r_cnt     <= '0;
      r_bit     <= 3'd0;
      r_shift   <= 8'h00;
      r_asm_st  <= WAIT_HI;
      r_hold    <= 8'h00;
      r_cmd     <= 16'h0000;
      r_cmd_rdy <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      r_byte_st <= w_byte_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit     <= w_bit_nxt;
      r_shift   <= w_shift_nxt;
      r_asm_st  <= w_asm_nxt;
      r_hold    <= w_hold_nxt;
      r_cmd     <= w_cmd_nxt;
      r_cmd_rdy <= w_rdy_nxt;
      r_frm_err <= w_frm_err;
    end
  end

  assign cmd     = r_cmd;
  assign cmd_rdy = r_cmd_rdy;
  assign frm_err = r_frm_err;

endmodule

// File: tb/tb_uart_cmd_rcv.sv
// Directed bench for uart_cmd_rcv with a shortened bit period.
// RX and clr_cmd_rdy are driven and outputs sampled on the falling clock edge.
module tb_uart_cmd_rcv;

  localparam int BAUD = 16;
  localparam int HALF = 8;
  // Start edge to cmd_rdy: 2 sync flops + stop sample + 1 register edge.
  localparam int LAT  = 2 + HALF + 9 * BAUD + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic        clr_cmd_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        frm_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_start  = 0;
  int rise_cyc = 0;
  int err_cyc  = 0;
  logic prev_rdy = 1'b0;

  uart_cmd_rcv #(.BAUD_CNT(BAUD), .HALF_CNT(HALF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .clr_cmd_rdy(clr_cmd_rdy),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .frm_err    (frm_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (cmd_rdy && !prev_rdy) rise_cyc = cyc;
    prev_rdy = cmd_rdy;
    if (frm_err) err_cyc++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame followed by a 3-bit idle gap; caller is at a falling edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    RX = 1'b0;
    t_start = cyc;
    wait_neg(BAUD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      wait_neg(BAUD);
    end
    RX = stop_bit;
    wait_neg(BAUD);
    RX = 1'b1;
    wait_neg(3 * BAUD);
  endtask

  initial begin
    rst_n = 1'b0;
    RX = 1'b1;
    clr_cmd_rdy = 1'b0;
    wait_neg(4);
    check("reset_cmd", 32'(cmd), 32'h0000);
    check("reset_rdy", 32'(cmd_rdy), 32'h0);
    check("reset_err", 32'(frm_err), 32'h0);
    rst_n = 1'b1;
    wait_neg(4);

    // Two good frames build a command.
    rise_cyc = 0;
    send_frame(8'hA5, 1'b1);
    check("hi_only_rdy", 32'(cmd_rdy), 32'h0);
    send_frame(8'h3C, 1'b1);
    check("a53c_cmd", 32'(cmd), 32'hA53C);
    check("a53c_rdy", 32'(cmd_rdy), 32'h1);
    check("a53c_latency", 32'(rise_cyc - t_start), 32'(LAT));
    check("a53c_no_err", 32'(err_cyc), 32'h0);

    // Consumer clear, then a lone high byte keeps cmd_rdy low.
    clr_cmd_rdy = 1'b1;
    wait_neg(1);
    clr_cmd_rdy = 1'b0;
    check("clr_rdy", 32'(cmd_rdy), 32'h0);
    check("clr_cmd_held", 32'(cmd), 32'hA53C);
    send_frame(8'h12, 1'b1);
    check("hi12_rdy", 32'(cmd_rdy), 32'h0);

    // Bad stop bit drops both the pending 8'h12 and 8'h55.
    send_frame(8'h55, 1'b0);
    check("ferr_pulse_width", 32'(err_cyc), 32'h1);
    check("ferr_cmd_held", 32'(cmd), 32'hA53C);
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    check("0102_cmd", 32'(cmd), 32'h0102);
    check("0102_rdy", 32'(cmd_rdy), 32'h1);

    // Low glitch shorter than half a bit is ignored.
    RX = 1'b0;
    wait_neg(HALF / 2);
    RX = 1'b1;
    wait_neg(2 * BAUD);
    send_frame(8'h7E, 1'b1);
    send_frame(8'h81, 1'b1);
    check("7e81_cmd", 32'(cmd), 32'h7E81);
    check("glitch_no_err", 32'(err_cyc), 32'h1);

    // Reset during bit 4 of the low byte abandons everything.
    send_frame(8'hA5, 1'b1);
    check("new_hi_clears_rdy", 32'(cmd_rdy), 32'h0);
    send_frame(8'h3C, 1'b1);
    check("a53c_again", 32'(cmd), 32'hA53C);
    send_frame(8'hA5, 1'b1);
    fork
      send_frame(8'h3C, 1'b1);
      begin
        wait_neg(5 * BAUD + HALF);
        rst_n = 1'b0;
        wait_neg(2);
        check("midrst_cmd", 32'(cmd), 32'h0000);
        check("midrst_rdy", 32'(cmd_rdy), 32'h0);
      end
    join
    rst_n = 1'b1;
    wait_neg(4);
    check("postrst_cmd", 32'(cmd), 32'h0000);
    send_frame(8'hDE, 1'b1);
    send_frame(8'hAD, 1'b1);
    check("dead_cmd", 32'(cmd), 32'hDEAD);
    check("dead_rdy", 32'(cmd_rdy), 32'h1);

    // clr_cmd_rdy held across the setting edge: set wins.
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        clr_cmd_rdy = 1'b1;
        wait_neg(LAT);
        check("set_vs_clr_rdy", 32'(cmd_rdy), 32'h1);
        clr_cmd_rdy = 1'b0;
      end
    join
    check("1122_cmd", 32'(cmd), 32'h1122);
    check("1122_rdy_kept", 32'(cmd_rdy), 32'h1);

    // Back-to-back command without a clear overwrites.
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    check("3344_cmd", 32'(cmd), 32'h3344);
    check("3344_rdy", 32'(cmd_rdy), 32'h1);
    check("final_err_count", 32'(err_cyc), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cmd_rcv.md
UART_CMD_RCV -- requirements
Module: uart_cmd_rcv

Interface
REQ-001 SHALL have parameter: BAUD_CNT, 2604, clocks per bit period (50 MHz clock / 19200 baud).
REQ-002 SHALL have parameter: HALF_CNT, 1302, clocks from start-bit edge to start-bit mid-sample (BAUD_CNT/2).
REQ-003 SHALL have one clock; reset is asynchronous and active-low: clk  input  1  system clock, all flops on rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port: RX  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-006 SHALL have port: clr_cmd_rdy  input  1  consumer acknowledge, clears cmd_rdy.
REQ-007 SHALL have port: cmd  output  16  assembled command, high byte = first received frame.
REQ-008 SHALL have port: cmd_rdy  output  1  cmd holds a complete, valid two-byte command.
REQ-009 SHALL have port: frm_err  output  1  one-clock pulse on a frame with a bad stop bit.

Function
REQ-010 SHALL pass RX through two flops, both preset to 1; all downstream logic uses only the second flop.
REQ-011 SHALL run a byte FSM with states IDLE, START, DATA, STOP.
REQ-012 IDLE -> START on synchronized falling edge; baud counter loaded with HALF_CNT.
REQ-013 START: at counter 0, line low -> DATA, counter = BAUD_CNT; line high -> IDLE (glitch, no error, no frm_err).
REQ-014 DATA: sample at each counter 0, shift into byte register LSB first, reload BAUD_CNT; after 8th sample -> STOP.
REQ-015 STOP: at counter 0, line high -> byte accepted; line low -> byte discarded, frm_err pulses one clock; both -> IDLE.
REQ-016 Stop sample SHALL occur HALF_CNT + 9*BAUD_CNT clocks after the synchronized falling edge (+/-1 clock).
REQ-017 SHALL run an assembler FSM with states WAIT_HI, WAIT_LO.
REQ-018 WAIT_HI: accepted byte stored in hold register -> WAIT_LO.
REQ-019 WAIT_LO: accepted byte -> cmd = {hold, byte}, cmd_rdy set, -> WAIT_HI.
REQ-020 Frame error in either assembler state SHALL return the assembler to WAIT_HI; partial high byte discarded.
REQ-021 cmd and cmd_rdy SHALL update on the clock edge following the accepting stop sample.
REQ-022 cmd_rdy SHALL clear on clr_cmd_rdy high, or when the assembler leaves WAIT_HI on a new high byte.
REQ-023 Same-cycle set and clr_cmd_rdy: set SHALL win, cmd_rdy = 1.
REQ-024 A new complete command while cmd_rdy = 1 SHALL overwrite cmd; cmd_rdy stays 1.
REQ-025 cmd SHALL hold its value between commands and SHALL NOT change on a frame error.
REQ-026 Baud counter SHALL be wide enough for BAUD_CNT (12 bits at default) and SHALL never wrap in IDLE (held at 0).

Reset
REQ-027 rst_n low SHALL immediately force: cmd = 16'h0000, cmd_rdy = 0, frm_err = 0, both sync flops = 1, byte FSM IDLE, assembler WAIT_HI, counter 0, hold 8'h00.
REQ-028 Reset mid-frame SHALL abandon the frame; after release a mid-frame RX transition SHALL be treated as a fresh start edge.

Verification
REQ-029 Frames 8'hA5 then 8'h3C, BAUD_CNT spacing, idle gap 3 bit periods -> cmd = 16'hA53C, cmd_rdy = 1 one clock after second stop sample, frm_err never high.
REQ-030 cmd_rdy = 1, clr_cmd_rdy one clock -> cmd_rdy = 0 next clock, cmd still 16'hA53C; then frame 8'h12 -> cmd_rdy stays 0.
REQ-031 Frame 8'h55 with stop bit 0, then 8'h01, 8'h02 -> frm_err one-clock pulse, cmd = 16'h0102, 8'h55 not used.
REQ-032 RX low pulse of 500 clocks, then 8'h7E and 8'h81 -> no frm_err, cmd = 16'h7E81.
REQ-033 rst_n low during bit 4 of the low byte after cmd = 16'hA53C -> cmd = 16'h0000, cmd_rdy = 0; next two frames 8'hDE, 8'hAD -> cmd = 16'hDEAD.
REQ-034 Set coincident with clr_cmd_rdy; also two back-to-back commands without clear -> cmd_rdy = 1, cmd = second command.
